// File: rtl/solver_seq_ctrl.sv
// solver_seq_ctrl: sequences repeated steps of an external ODE solver core,
// decimates the resulting state trajectory and hands samples to a consumer
// through a single-entry valid/ready register.
//
// Ports:
//   CLK_i, RSTN_i        clock, asynchronous active-low reset
//   EN_i                 run request (level); dropping it aborts a run
//   NSTEPS_i, DECIM_i    steps per run and sample decimation, latched at start
//   CORE_START_o         one-cycle launch pulse to the solver core
//   CORE_FINISHED_i      one-cycle step-complete pulse, CORE_X/Y/Z_i valid
//   SMP_*                captured sample, valid/ready handshake, last flag
//   STEP_CNT_o           steps completed in the current/last run
//   BUSY_o, DONE_o       run status
module solver_seq_ctrl #(
    parameter int unsigned W     = 28,
    parameter int unsigned CNT_W = 16
) (
    input  logic                CLK_i,
    input  logic                RSTN_i,
    input  logic                EN_i,
    input  logic [CNT_W-1:0]    NSTEPS_i,
    input  logic [7:0]          DECIM_i,
    output logic                CORE_START_o,
    input  logic                CORE_FINISHED_i,
    input  logic signed [W-1:0] CORE_X_i,
    input  logic signed [W-1:0] CORE_Y_i,
    input  logic signed [W-1:0] CORE_Z_i,
    output logic                SMP_VALID_o,
    input  logic                SMP_READY_i,
    output logic signed [W-1:0] SMP_X_o,
    output logic signed [W-1:0] SMP_Y_o,
    output logic signed [W-1:0] SMP_Z_o,
    output logic                SMP_LAST_o,
    output logic [CNT_W-1:0]    STEP_CNT_o,
    output logic                BUSY_o,
    output logic                DONE_o
);

    localparam int unsigned DEC_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      nsteps_q, nsteps_d;
    logic [CNT_W-1:0]      step_cnt_q, step_cnt_d;
    logic [DEC_W-1:0]      decim_q, decim_d;
    logic [DEC_W-1:0]      dec_cnt_q, dec_cnt_d;
    logic                  abort_q, abort_d;
    logic                  smp_valid_q, smp_valid_d;
    logic                  smp_last_q, smp_last_d;
    logic signed [W-1:0]   smp_x_q, smp_x_d;
    logic signed [W-1:0]   smp_y_q, smp_y_d;
    logic signed [W-1:0]   smp_z_q, smp_z_d;
    logic                  busy_q, done_q;

    logic [CNT_W-1:0]      step_inc;
    logic [DEC_W-1:0]      dec_inc;
    logic                  last_step;

    assign step_inc  = step_cnt_q + CNT_W'(1);
    assign dec_inc   = dec_cnt_q + DEC_W'(1);
    assign last_step = (step_inc == nsteps_q);

    // State and datapath registers.
    always_ff @(posedge CLK_i or negedge RSTN_i) begin
        if (!RSTN_i) begin
            state_q     <= S_IDLE;
            nsteps_q    <= '0;
            step_cnt_q  <= '0;
            decim_q     <= '0;
            dec_cnt_q   <= '0;
            abort_q     <= 1'b0;
            smp_valid_q <= 1'b0;
            smp_last_q  <= 1'b0;
            smp_x_q     <= '0;
            smp_y_q     <= '0;
            smp_z_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            nsteps_q    <= nsteps_d;
            step_cnt_q  <= step_cnt_d;
            decim_q     <= decim_d;
            dec_cnt_q   <= dec_cnt_d;
            abort_q     <= abort_d;
            smp_valid_q <= smp_valid_d;
            smp_last_q  <= smp_last_d;
            smp_x_q     <= smp_x_d;
            smp_y_q     <= smp_y_d;
            smp_z_q     <= smp_z_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d     = state_q;
        nsteps_d    = nsteps_q;
        step_cnt_d  = step_cnt_q;
        decim_d     = decim_q;
        dec_cnt_d   = dec_cnt_q;
        abort_d     = abort_q;
        smp_valid_d = smp_valid_q;
        smp_last_d  = smp_last_q;
        smp_x_d     = smp_x_q;
        smp_y_d     = smp_y_q;
        smp_z_d     = smp_z_q;

        case (state_q)
            S_IDLE: begin
                if (EN_i && (NSTEPS_i != '0)) begin
                    nsteps_d   = NSTEPS_i;
                    decim_d    = (DECIM_i == '0) ? DEC_W'(1) : DECIM_i;
                    step_cnt_d = '0;
                    dec_cnt_d  = '0;
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = EN_i ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (!EN_i) begin
                    abort_d = 1'b1;
                end
                if (CORE_FINISHED_i) begin
                    step_cnt_d = step_inc;
                    if (abort_q || !EN_i) begin
                        // Aborted step still counts, but its result is discarded.
                        state_d = S_IDLE;
                    end else if ((dec_inc == decim_q) || last_step) begin
                        smp_x_d     = CORE_X_i;
                        smp_y_d     = CORE_Y_i;
                        smp_z_d     = CORE_Z_i;
                        smp_valid_d = 1'b1;
                        smp_last_d  = last_step;
                        dec_cnt_d   = '0;
                        state_d     = S_HOLD;
                    end else begin
                        dec_cnt_d = dec_inc;
                        state_d   = last_step ? S_DONE : S_LAUNCH;
                    end
                end
            end
            S_HOLD: begin
                if (!EN_i) begin
                    smp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (smp_valid_q && SMP_READY_i) begin
                    smp_valid_d = 1'b0;
                    state_d     = smp_last_q ? S_DONE : S_LAUNCH;
                end
            end
            S_DONE: begin
                if (!EN_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_IDLE) begin
            abort_d = 1'b0;
        end
    end

    // Launch pulse is suppressed when the run is withdrawn in LAUNCH.
    assign CORE_START_o = (state_q == S_LAUNCH) && EN_i;
    assign SMP_VALID_o  = smp_valid_q;
    assign SMP_X_o      = smp_x_q;
    assign SMP_Y_o      = smp_y_q;
    assign SMP_Z_o      = smp_z_q;
    assign SMP_LAST_o   = smp_last_q;
    assign STEP_CNT_o   = step_cnt_q;
    assign BUSY_o       = busy_q;
    assign DONE_o       = done_q;

endmodule

// File: tb/tb_solver_seq_ctrl.sv
// Testbench for solver_seq_ctrl: a solver-core responder and sample consumer
// run inline each cycle; expected samples come from the decimation rule applied
// to the per-step core results the bench itself generated.
module tb_solver_seq_ctrl;

    localparam int unsigned W     = 28;
    localparam int unsigned CNT_W = 16;

    logic                clk;
    logic                rst_n;
    logic                en;
    logic [CNT_W-1:0]    nsteps;
    logic [7:0]          decim;
    logic                core_start;
    logic                fin;
    logic signed [W-1:0] cx, cy, cz;
    logic                smp_valid;
    logic                ready;
    logic signed [W-1:0] smp_x, smp_y, smp_z;
    logic                smp_last;
    logic [CNT_W-1:0]    step_cnt;
    logic                busy;
    logic                done;

    solver_seq_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
        .CLK_i           (clk),
        .RSTN_i          (rst_n),
        .EN_i            (en),
        .NSTEPS_i        (nsteps),
        .DECIM_i         (decim),
        .CORE_START_o    (core_start),
        .CORE_FINISHED_i (fin),
        .CORE_X_i        (cx),
        .CORE_Y_i        (cy),
        .CORE_Z_i        (cz),
        .SMP_VALID_o     (smp_valid),
        .SMP_READY_i     (ready),
        .SMP_X_o         (smp_x),
        .SMP_Y_o         (smp_y),
        .SMP_Z_o         (smp_z),
        .SMP_LAST_o      (smp_last),
        .STEP_CNT_o      (step_cnt),
        .BUSY_o          (busy),
        .DONE_o          (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors;
    int miscompares;

    // Reference model state.
    logic signed [W-1:0] vx[$], vy[$], vz[$];
    int  exp_steps[$];
    int  cur_nsteps;
    int  core_timer;
    int  core_lat;
    int  starts;
    int  got;
    int  ready_mode;
    bit  stall_first;
    int  stall_left;
    bit  prev_valid;
    bit  prev_accept;
    logic signed [W-1:0] px, py, pz;
    logic pl;

    // One cycle: observe at the falling edge, then drive inputs for the next rising edge.
    task automatic tick();
        int k;
        @(negedge clk);
        fin = 1'b0;
        if (core_timer > 0) begin
            core_timer--;
            if (core_timer == 0) begin
                fin = 1'b1;
                cx  = W'($urandom);
                cy  = W'($urandom);
                cz  = W'($urandom);
                vx.push_back(cx);
                vy.push_back(cy);
                vz.push_back(cz);
            end
        end
        if (stall_left > 0) begin
            vectors++;
            if (core_start !== 1'b0) begin
                miscompares++;
                $display("FAIL start_during_stall: got %b want 0", core_start);
            end
        end
        if (core_start === 1'b1) begin
            starts++;
            core_timer = core_lat;
        end
        if (prev_valid && !prev_accept && smp_valid) begin
            vectors++;
            if (smp_x !== px || smp_y !== py || smp_z !== pz || smp_last !== pl) begin
                miscompares++;
                $display("FAIL sample_stable: got %h/%h/%h/%b want %h/%h/%h/%b",
                         smp_x, smp_y, smp_z, smp_last, px, py, pz, pl);
            end
        end
        if (stall_first && smp_valid) begin
            stall_first = 1'b0;
            stall_left  = 10;
        end
        if (stall_left > 0) begin
            ready = 1'b0;
            stall_left--;
        end else if (ready_mode == 0) begin
            ready = 1'b1;
        end else if (ready_mode == 1) begin
            ready = 1'($urandom_range(0, 1));
        end else begin
            ready = 1'b0;
        end
        prev_accept = 1'b0;
        if (smp_valid === 1'b1 && ready && en) begin
            prev_accept = 1'b1;
            vectors++;
            if (got >= exp_steps.size()) begin
                miscompares++;
                $display("FAIL extra_sample: got sample #%0d want only %0d", got + 1, exp_steps.size());
            end else begin
                k = exp_steps[got];
                if (vx.size() < k || smp_x !== vx[k-1] || smp_y !== vy[k-1] || smp_z !== vz[k-1]
                    || smp_last !== (k == cur_nsteps)) begin
                    miscompares++;
                    $display("FAIL sample_value #%0d (step %0d): got %h/%h/%h/%b want %h/%h/%h/%b",
                             got, k, smp_x, smp_y, smp_z, smp_last,
                             (vx.size() >= k) ? vx[k-1] : W'(0), (vy.size() >= k) ? vy[k-1] : W'(0),
                             (vz.size() >= k) ? vz[k-1] : W'(0), (k == cur_nsteps));
                end
            end
            got++;
        end
        prev_valid = smp_valid;
        px = smp_x; py = smp_y; pz = smp_z; pl = smp_last;
    endtask

    task automatic setup_job(input int ns, input int dc, input int lat, input int rmode, input bit stall);
        int eff;
        vx.delete(); vy.delete(); vz.delete(); exp_steps.delete();
        starts = 0; got = 0; core_timer = 0; core_lat = lat;
        ready_mode = rmode; stall_first = stall; stall_left = 0;
        cur_nsteps = ns;
        eff = (dc == 0) ? 1 : dc;
        for (int k = 1; k <= ns; k++) begin
            if ((k % eff) == 0 || k == ns) exp_steps.push_back(k);
        end
        nsteps = CNT_W'(ns);
        decim  = 8'(dc);
    endtask

    task automatic run_job(input string name, input int ns, input int dc, input int lat,
                           input int rmode, input bit stall);
        int cycles;
        setup_job(ns, dc, lat, rmode, stall);
        en = 1'b1;
        cycles = 0;
        while (done !== 1'b1 && cycles < 3000) begin
            tick();
            cycles++;
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s timeout: got done=%b want 1 within 3000 cycles", name, done);
        end
        vectors++;
        if (starts != ns) begin
            miscompares++;
            $display("FAIL %s start_count: got %0d want %0d", name, starts, ns);
        end
        vectors++;
        if (got != exp_steps.size()) begin
            miscompares++;
            $display("FAIL %s sample_count: got %0d want %0d", name, got, exp_steps.size());
        end
        vectors++;
        if (step_cnt !== CNT_W'(ns) || busy !== 1'b1 || smp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s end_state: got cnt=%0d busy=%b valid=%b want cnt=%0d busy=1 valid=0",
                     name, step_cnt, busy, smp_valid, ns);
        end
        en = 1'b0;
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || step_cnt !== CNT_W'(ns)) begin
            miscompares++;
            $display("FAIL %s after_release: got busy=%b done=%b cnt=%0d want 0/0/%0d",
                     name, busy, done, step_cnt, ns);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; fin = 1'b0; ready = 1'b0;
        nsteps = '0; decim = '0; cx = '0; cy = '0; cz = '0;
        core_timer = 0; core_lat = 1; ready_mode = 0; stall_left = 0; stall_first = 1'b0;
        prev_valid = 1'b0; prev_accept = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        vectors++;
        if (core_start !== 1'b0 || smp_valid !== 1'b0 || smp_last !== 1'b0 || smp_x !== '0
            || smp_y !== '0 || smp_z !== '0 || step_cnt !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got start=%b v=%b l=%b x=%h y=%h z=%h cnt=%0d busy=%b done=%b want all 0",
                     core_start, smp_valid, smp_last, smp_x, smp_y, smp_z, step_cnt, busy, done);
        end
    endtask

    task automatic test_zero_nsteps();
        setup_job(0, 3, 2, 0, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_nsteps_busy: got %b want 0", busy);
            end
        end
        vectors++;
        if (starts != 0) begin
            miscompares++;
            $display("FAIL zero_nsteps_start: got %0d pulses want 0", starts);
        end
        en = 1'b0;
        tick();
        run_job("decim_zero", 2, 0, 3, 0, 1'b0);
    endtask

    task automatic test_abort();
        int cycles;
        setup_job(8, 1, 4, 0, 1'b0);
        en = 1'b1;
        cycles = 0;
        while (starts < 2 && cycles < 500) begin
            tick();
            cycles++;
        end
        tick();
        en = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        vectors++;
        if (starts != 2 || step_cnt !== CNT_W'(2) || done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_wait: got starts=%0d cnt=%0d done=%b busy=%b want 2/2/0/0",
                     starts, step_cnt, done, busy);
        end
        vectors++;
        if (got != 1) begin
            miscompares++;
            $display("FAIL abort_samples: got %0d want 1", got);
        end
    endtask

    task automatic test_reset_mid_hold();
        int cycles;
        setup_job(3, 1, 2, 2, 1'b0);
        en = 1'b1;
        cycles = 0;
        while (smp_valid !== 1'b1 && cycles < 500) begin
            tick();
            cycles++;
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (core_start !== 1'b0 || smp_valid !== 1'b0 || smp_last !== 1'b0 || smp_x !== '0
            || smp_y !== '0 || smp_z !== '0 || step_cnt !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got start=%b v=%b l=%b x=%h cnt=%0d busy=%b done=%b want all 0",
                     core_start, smp_valid, smp_last, smp_x, step_cnt, busy, done);
        end
        en = 1'b0;
        ready_mode = 0;
        tick();
        rst_n = 1'b1;
        starts = 0;
        core_timer = 1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (busy !== 1'b0 || step_cnt !== '0 || starts != 0 || smp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL spurious_finish: got busy=%b cnt=%0d starts=%0d valid=%b want 0/0/0/0",
                     busy, step_cnt, starts, smp_valid);
        end
        run_job("after_reset", 3, 1, 2, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 6; j++) begin
            run_job("random", int'($urandom_range(1, 10)), int'($urandom_range(0, 4)),
                    int'($urandom_range(1, 6)), 1, 1'b0);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        run_job("n4_d2", 4, 2, 5, 0, 1'b0);
        run_job("n5_d2", 5, 2, 5, 0, 1'b0);
        run_job("stall", 3, 1, 3, 0, 1'b1);
        run_job("min_period", 6, 3, 1, 0, 1'b0);
        test_zero_nsteps();
        test_abort();
        test_reset_mid_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
